// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction ROM with a byte-stream program loader.
//
// The CPU fetches 32-bit words combinationally by byte address. A loader FSM
// (IDLE/COLLECT/WRITE/DONE) assembles incoming bytes big-endian into words
// and writes them sequentially from word 0. Fetches return 0 (NOP) while a
// load is in progress.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   rom_ce_i, rom_addr_i        fetch enable and byte address from the CPU
//   rom_data_o                  fetched instruction word (combinational)
//   ld_start_i                  begin a program load
//   ld_valid_i, ld_byte_i       load byte stream
//   ld_last_i                   marks the final byte of a load
//   ld_ready_o                  loader accepts a byte this cycle
//   busy_o                      load in progress
//   ld_done_o                   load complete, held until next start
//   ld_count_o                  words written in the current/last load
//   par_err_o                   sticky fetch parity error
//
// Optional feature: define INST_ROM_PARITY_EN to store an even-parity bit per
// word and check it on every fetch.

module inst_rom_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_byte_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              busy_o,
    output logic              ld_done_o,
    output logic [ADDR_W:0]   ld_count_o,
    output logic              par_err_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   word_ptr_q, word_ptr_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         word_q, word_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                mem_we;

    logic [31:0]         mem [DEPTH];

    // Next-state and datapath updates for the loader
    always_comb begin
        state_d    = state_q;
        word_ptr_d = word_ptr_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        last_d     = last_q;
        count_d    = count_q;
        done_d     = done_q;
        mem_we     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (ld_start_i) begin
                    state_d    = COLLECT;
                    word_ptr_d = '0;
                    byte_cnt_d = 2'd0;
                    count_d    = '0;
                    done_d     = 1'b0;
                end
            end
            COLLECT: begin
                if (ld_valid_i) begin
                    // First byte of a word clears the rest so a short final
                    // word is zero-filled in its low bytes.
                    case (byte_cnt_q)
                        2'd0:    word_d = {ld_byte_i, 24'h0};
                        2'd1:    word_d[23:16] = ld_byte_i;
                        2'd2:    word_d[15:8]  = ld_byte_i;
                        default: word_d[7:0]   = ld_byte_i;
                    endcase
                    last_d = ld_last_i;
                    if (byte_cnt_q == 2'd3 || ld_last_i) begin
                        state_d    = WRITE;
                        byte_cnt_d = 2'd0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                mem_we     = 1'b1;
                word_ptr_d = word_ptr_q + ADDR_W'(1);
                count_d    = count_q + CNT_W'(1);
                // Stop at the last memory word rather than wrapping
                if (last_q || word_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == COLLECT);
        busy_d  = (state_d == COLLECT) || (state_d == WRITE);
    end

    // Loader state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            word_ptr_q <= '0;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'h0;
            last_q     <= 1'b0;
            count_q    <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_ptr_q <= word_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            last_q     <= last_d;
            count_q    <= count_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Program memory: deliberately not reset so a load survives reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_ptr_q] <= word_q;
        end
    end

    logic [ADDR_W-1:0] fetch_idx;
    logic [31:0]       rd_word;
    logic              fetch_en;
    logic              unused_addr_bits;

    assign fetch_idx        = rom_addr_i[ADDR_W+1:2];
    assign rd_word          = mem[fetch_idx];
    assign fetch_en         = rom_ce_i && !busy_q;
    assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

`ifdef INST_ROM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_ok;
    logic par_err_q;

    // Stored bit makes word plus parity even
    always_ff @(posedge clk) begin
        if (mem_we) begin
            par_mem[word_ptr_q] <= ^word_q;
        end
    end

    assign par_ok = ((^rd_word) == par_mem[fetch_idx]);

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_q <= 1'b0;
        end else if (fetch_en && !par_ok) begin
            par_err_q <= 1'b1;
        end
    end

    assign rom_data_o = (fetch_en && par_ok) ? rd_word : 32'h0;
    assign par_err_o  = par_err_q;
`else
    assign rom_data_o = fetch_en ? rd_word : 32'h0;
    assign par_err_o  = 1'b0;
`endif

    assign ld_ready_o = ready_q;
    assign busy_o     = busy_q;
    assign ld_done_o  = done_q;
    assign ld_count_o = count_q;

endmodule

// File: doc/inst_rom_loader.md
INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of memory depth in 32-bit words (DEPTH = 2**ADDR_W).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port rom_ce_i, input, 1, fetch enable from CPU.
REQ-005 SHALL have port rom_addr_i, input, 32, byte address from CPU PC.
REQ-006 SHALL have port rom_data_o, output, 32, instruction word to CPU.
REQ-007 SHALL have port ld_start_i, input, 1, begin a program load.
REQ-008 SHALL have port ld_valid_i, input, 1, load byte valid.
REQ-009 SHALL have port ld_byte_i, input, 8, load byte.
REQ-010 SHALL have port ld_last_i, input, 1, qualifies final byte of a load.
REQ-011 SHALL have port ld_ready_o, output, 1, loader accepts a byte this cycle.
REQ-012 SHALL have port busy_o, output, 1, load in progress.
REQ-013 SHALL have port ld_done_o, output, 1, load completed, held until next ld_start_i.
REQ-014 SHALL have port ld_count_o, output, ADDR_W+1, words written in current/last load.
REQ-015 SHALL have port par_err_o, output, 1, sticky fetch parity error (see Configuration).

Function
REQ-016 Fetch SHALL be combinational: rom_data_o = mem[rom_addr_i[ADDR_W+1:2]] when rom_ce_i=1 and busy_o=0; otherwise 32'h0 (NOP); rom_addr_i[1:0] and bits above ADDR_W+1 ignored.
REQ-017 Loader FSM states SHALL be IDLE, COLLECT, WRITE, DONE.
REQ-018 IDLE or DONE with ld_start_i=1 -> COLLECT; word pointer, byte counter, ld_count_o cleared; ld_done_o cleared.
REQ-019 ld_ready_o SHALL be 1 only in COLLECT; a byte transfers when ld_valid_i & ld_ready_o.
REQ-020 Bytes SHALL assemble big-endian: first byte of a word -> bits 31:24, fourth -> 7:0.
REQ-021 COLLECT -> WRITE after the fourth byte transfer, or on a transfer with ld_last_i=1; unfilled low bytes of a partial word SHALL be zero.
REQ-022 WRITE SHALL last exactly one cycle: mem[word_ptr] <= assembled word, word_ptr and ld_count_o increment.
REQ-023 WRITE -> DONE if the word carried ld_last_i or word_ptr was DEPTH-1 (no wrap); else -> COLLECT.
REQ-024 busy_o SHALL be 1 in COLLECT and WRITE.
REQ-025 ld_start_i in COLLECT or WRITE SHALL be ignored.
REQ-026 ld_valid_i outside COLLECT SHALL be ignored; no byte consumed.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, word pointer/byte counter 0, ld_count_o=0, ld_done_o=0, busy_o=0, ld_ready_o=0, par_err_o=0.
REQ-028 Memory contents SHALL NOT be reset; a load interrupted by reset leaves already-written words intact.

Configuration
REQ-029 With INST_ROM_PARITY_EN defined, each word SHALL store an even-parity bit computed in WRITE; a fetch with rom_ce_i=1, busy_o=0 and mismatching parity SHALL drive rom_data_o=0 and set par_err_o on the next clk edge, sticky until reset.
REQ-030 Without INST_ROM_PARITY_EN, no parity storage SHALL exist and par_err_o SHALL be constant 0.

Verification
REQ-031 Reset, ld_start, bytes 34 02 00 01 with ld_last on 4th -> mem[0]=32'h34020001, ld_count_o=1, ld_done_o=1; fetch addr 0x0 ce=1 -> rom_data_o=32'h34020001.
REQ-032 Load 3 bytes AA BB CC, ld_last on 3rd -> mem[0]=32'hAABBCC00.
REQ-033 ADDR_W=2, stream 20 bytes without ld_last -> 4 words written, DONE after 16th byte, ld_ready_o=0 thereafter, ld_count_o=4.
REQ-034 During COLLECT, fetch ce=1 addr 0x4 -> rom_data_o=0; busy_o=1; ld_start_i pulse ignored.
REQ-035 rst low mid-word (after 2 bytes) -> IDLE, ld_ready_o=0, previously written words still fetchable.
REQ-036 INST_ROM_PARITY_EN: force a stored bit flip at mem[1], fetch 0x4 -> rom_data_o=0, par_err_o=1 next cycle and stays 1.
